// File: rtl/alarm_pkg.sv
// Shared state encoding for the alarm zone controller.
package alarm_pkg;

    localparam logic [1:0] ST_DISARMED_ENC = 2'd0;
    localparam logic [1:0] ST_ARMED_ENC    = 2'd1;
    localparam logic [1:0] ST_ENTRY_ENC    = 2'd2;
    localparam logic [1:0] ST_ALARM_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_DISARMED = ST_DISARMED_ENC,
        ST_ARMED    = ST_ARMED_ENC,
        ST_ENTRY    = ST_ENTRY_ENC,
        ST_ALARM    = ST_ALARM_ENC
    } alarm_state_e;

endpackage

// File: rtl/alarm_debounce.sv
// One-bit 2-flop synchroniser followed by a debouncer. The debounced level
// flips only after the synchronised level has disagreed with it on
// DEBOUNCE_CYCLES consecutive edges (plus the flip edge itself), so a
// stable input change shows up 2+DEBOUNCE_CYCLES edges after it is sampled.
module alarm_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Synchronise the raw level, then count consecutive disagreements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Alarm zone controller: debounced zone inputs drive a four-state
// arm/entry/alarm machine with per-zone sticky trip latches.
// Disarm always wins; arm is only honoured from DISARMED with no active zone.
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int                  N_ZONES         = 4,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter int                  ENTRY_DELAY     = 16,
    parameter logic [N_ZONES-1:0]  INSTANT_MASK    = {N_ZONES{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] zone_in,
    input  logic [N_ZONES-1:0] zone_en,
    input  logic               arm,
    input  logic               disarm,
    output logic [1:0]         state,
    output logic               armed,
    output logic               siren,
    output logic [N_ZONES-1:0] zone_latched
);

    localparam int CW = (ENTRY_DELAY > 1) ? $clog2(ENTRY_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ENTRY_DELAY - 1);

    logic [N_ZONES-1:0] w_level;
    logic [N_ZONES-1:0] w_active;
    logic               w_any;
    logic               w_inst;

    alarm_state_e       r_state;
    alarm_state_e       w_next_state;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_next_cnt;
    logic               r_armed;
    logic               r_siren;
    logic [N_ZONES-1:0] r_latched;
    logic [N_ZONES-1:0] w_next_latched;

    genvar g;
    generate
        for (g = 0; g < N_ZONES; g++) begin : g_zone
            alarm_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_din  (zone_in[g]),
                .o_level(w_level[g])
            );
        end
    endgenerate

    assign w_active = w_level & zone_en;
    assign w_any    = |w_active;
    assign w_inst   = |(w_active & INSTANT_MASK);

    // State, entry counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_DISARMED;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
            r_siren   <= 1'b0;
            r_latched <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_armed   <= (w_next_state != ST_DISARMED);
            r_siren   <= (w_next_state == ST_ALARM);
            r_latched <= w_next_latched;
        end
    end

    // Next-state, entry countdown and latch update; disarm overrides all.
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_latched = r_latched;
        unique case (r_state)
            ST_DISARMED: begin
                w_next_cnt = '0;
                if (arm && !w_any) w_next_state = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_inst) begin
                    w_next_state = ST_ALARM;
                end else if (w_any) begin
                    w_next_state = ST_ENTRY;
                    w_next_cnt   = CNT_LOAD;
                end
            end
            ST_ENTRY: begin
                if (w_inst || r_cnt == '0) begin
                    w_next_state = ST_ALARM;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            ST_ALARM: begin
                w_next_state = ST_ALARM;
            end
            default: begin
                w_next_state = ST_DISARMED;
                w_next_cnt   = '0;
            end
        endcase
        if (r_state != ST_DISARMED) w_next_latched = r_latched | w_active;
        if (disarm) begin
            w_next_state   = ST_DISARMED;
            w_next_cnt     = '0;
            w_next_latched = '0;
        end
    end

    assign state        = r_state;
    assign armed        = r_armed;
    assign siren        = r_siren;
    assign zone_latched = r_latched;

endmodule

// File: doc/alarm_zone_ctrl.md
ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 SHALL have parameter N_ZONES, default 4: number of sensor zones (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a zone change (>=1).
REQ-003 SHALL have parameter ENTRY_DELAY, default 16: cycles spent in ENTRY before ALARM (>=1).
REQ-004 SHALL have parameter INSTANT_MASK, default {N_ZONES{1'b0}}: zones whose trigger bypasses the entry delay.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port zone_in, input, N_ZONES: raw asynchronous sensor levels, 1 = tripped.
REQ-008 SHALL have port zone_en, input, N_ZONES: per-zone enable; a 0 bit ignores that zone entirely.
REQ-009 SHALL have port arm, input, 1: synchronous arm request, sampled every cycle.
REQ-010 SHALL have port disarm, input, 1: synchronous disarm request, sampled every cycle.
REQ-011 SHALL have port state, output, 2: DISARMED=0, ARMED=1, ENTRY=2, ALARM=3.
REQ-012 SHALL have port armed, output, 1: high when state != DISARMED.
REQ-013 SHALL have port siren, output, 1: high when state == ALARM.
REQ-014 SHALL have port zone_latched, output, N_ZONES: sticky record of zones that tripped while armed.

Function
REQ-015 Each zone_in bit SHALL pass a 2-flop synchroniser, then a debouncer; all outputs SHALL be registered.
REQ-016 Debounced level SHALL change only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch shorter restarts the count.
REQ-017 End-to-end: a stable zone_in change SHALL appear on the debounced level exactly 2+DEBOUNCE_CYCLES edges after the first sampling edge.
REQ-018 "Active" SHALL mean debounced level 1 AND zone_en bit 1.
REQ-019 DISARMED: arm=1 with no active zone -> ARMED next edge; arm=1 with any active zone -> arm refused, stay DISARMED.
REQ-020 ARMED: any active INSTANT_MASK zone -> ALARM; else any active zone -> ENTRY, entry counter loaded with ENTRY_DELAY-1.
REQ-021 ENTRY: counter decrements each cycle; on the edge where counter==0 -> ALARM, so ENTRY lasts exactly ENTRY_DELAY cycles; active instant zone -> ALARM immediately.
REQ-022 ALARM: holds until disarm; zone clearing SHALL NOT leave ALARM.
REQ-023 disarm=1 in any state SHALL go to DISARMED next edge and clear zone_latched; disarm SHALL win over arm and over any trigger in the same cycle.
REQ-024 arm=1 outside DISARMED SHALL be ignored.
REQ-025 In ARMED/ENTRY/ALARM each active zone SHALL set its zone_latched bit on the next edge; bits SHALL stay set until disarm or reset.
REQ-026 Clearing zone_en mid-ENTRY SHALL NOT abort ENTRY; only disarm aborts.

Reset
REQ-027 rst_n low SHALL immediately force state=DISARMED, armed=0, siren=0, zone_latched=0, counters=0, synchroniser and debounced levels=0.
REQ-028 Reset asserted mid-ENTRY or mid-ALARM SHALL abort with no residual timing; after release the block SHALL behave as from power-up.

Structure
REQ-029 State encoding and localparams for the four states SHALL live in shared package alarm_pkg.
REQ-030 Synchroniser+debouncer SHALL be one sub-module, alarm_debounce (1 bit, parameter DEBOUNCE_CYCLES), instantiated N_ZONES times via generate.
REQ-031 Counter widths SHALL be derived with $clog2 of the parameters; no hard-coded widths.

Verification (defaults unless stated)
REQ-032 Arm with all zones clear, hold zone_in[0]=1 from edge 0 -> state ENTRY at edge 7, ALARM at edge 23, siren=1, zone_latched=4'b0001.
REQ-033 Same as REQ-032 but disarm pulsed at edge 15 -> state DISARMED at edge 16, siren never asserts, zone_latched=0.
REQ-034 INSTANT_MASK=4'b0010, armed, zone_in[1]=1 -> state jumps ARMED->ALARM at edge 7, no ENTRY cycle.
REQ-035 zone_in[2] pulses 3 cycles high while armed -> no state change, zone_latched stays 0; zone_en[3]=0 with zone_in[3]=1 -> arm accepted, no trigger.
REQ-036 zone_in[0] active, arm pulsed -> stays DISARMED; arm and disarm together in ARMED -> DISARMED.
REQ-037 rst_n low at cycle 10 of ENTRY -> all outputs 0 asynchronously; after release, arm accepted and a full 16-cycle entry delay observed.
